sprite_collision_detector: RTL and testbench

Downstream consumer of the frame encoder's per-pixel opacity stream. Captures one opacity bitmap per car sprite while the encoder rotates and writes each sprite, then, on request, scans the screen-space overlap of the two sprites pixel by pixel. It reports whether any pixel is opaque in both sprites, feeding the game-logic collision response.

---
 rtl/sprite_collision_detector.sv | 154 +++++++++++++++
 tb/tb_sprite_collision_detector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_collision_detector.sv
// Captures per-car opacity bitmaps from the encoder stream and scans their screen-space overlap for a shared opaque pixel.
// Optional build macro COLLISION_EARLY_EXIT_EN: stop the scan at the first hit.
module sprite_collision_detector #(
    parameter int IMAGE_SIZE = 32,
    parameter int COOR_WIDTH = 5,
    parameter int POS_WIDTH  = 11,
    parameter int CAR1_ID    = 0,
    parameter int CAR2_ID    = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_opacity_valid,
    input  logic                    i_opacity,
    input  logic [1:0]              i_object_id,
    input  logic [2*COOR_WIDTH-1:0] i_pixel_index,
    input  logic                    i_start,
    input  logic [POS_WIDTH-1:0]    i_car1_x,
    input  logic [POS_WIDTH-1:0]    i_car1_y,
    input  logic [POS_WIDTH-1:0]    i_car2_x,
    input  logic [POS_WIDTH-1:0]    i_car2_y,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_collision
);

    localparam int NPIX = IMAGE_SIZE * IMAGE_SIZE;
    localparam int DW   = POS_WIDTH + 1;
    localparam logic [COOR_WIDTH-1:0] CMAX  = COOR_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [DW-1:0]         LIMIT = DW'(IMAGE_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [NPIX-1:0]         bm1_q, bm2_q;
    logic [COOR_WIDTH-1:0]   h_q, h_d, v_q, v_d;
    logic [COOR_WIDTH-1:0]   h_start_q, h_start_d, h_end_q, h_end_d, v_end_q, v_end_d;
    logic [COOR_WIDTH-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic                    hit_q, hit_d, col_q, col_d;

    logic [DW-1:0]           dx_w, dy_w, dx_abs, dy_abs;
    logic                    far_w, hit_now, last_w;
    logic [COOR_WIDTH-1:0]   h_start_w, h_end_w, v_start_w, v_end_w, h2_w, v2_w;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bm1_q <= '0;
            bm2_q <= '0;
        end else if (state_q == S_IDLE && i_opacity_valid) begin
            if (i_object_id == 2'(CAR1_ID))
                bm1_q[i_pixel_index] <= i_opacity;
            else if (i_object_id == 2'(CAR2_ID))
                bm2_q[i_pixel_index] <= i_opacity;
        end
    end

    assign dx_w   = {1'b0, i_car2_x} - {1'b0, i_car1_x};
    assign dy_w   = {1'b0, i_car2_y} - {1'b0, i_car1_y};
    assign dx_abs = dx_w[DW-1] ? -dx_w : dx_w;
    assign dy_abs = dy_w[DW-1] ? -dy_w : dy_w;
    assign far_w  = (dx_abs >= LIMIT) || (dy_abs >= LIMIT);

    // Offsets are below IMAGE_SIZE here, so modular low-bit arithmetic gives exact bounds.
    assign h_start_w = dx_w[DW-1] ? '0 : dx_w[COOR_WIDTH-1:0];
    assign h_end_w   = dx_w[DW-1] ? CMAX + dx_w[COOR_WIDTH-1:0] : CMAX;
    assign v_start_w = dy_w[DW-1] ? '0 : dy_w[COOR_WIDTH-1:0];
    assign v_end_w   = dy_w[DW-1] ? CMAX + dy_w[COOR_WIDTH-1:0] : CMAX;

    assign h2_w    = h_q - dx_q;
    assign v2_w    = v_q - dy_q;
    assign hit_now = bm1_q[{v_q, h_q}] & bm2_q[{v2_w, h2_w}];
    assign last_w  = (h_q == h_end_q) && (v_q == v_end_q);

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        h_start_d = h_start_q;
        h_end_d   = h_end_q;
        v_end_d   = v_end_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        hit_d     = hit_q;
        col_d     = col_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_SETUP;
            end
            S_SETUP: begin
                col_d     = 1'b0;
                hit_d     = 1'b0;
                dx_d      = dx_w[COOR_WIDTH-1:0];
                dy_d      = dy_w[COOR_WIDTH-1:0];
                h_start_d = h_start_w;
                h_end_d   = h_end_w;
                v_end_d   = v_end_w;
                h_d       = h_start_w;
                v_d       = v_start_w;
                state_d   = far_w ? S_DONE : S_SCAN;
            end
            S_SCAN: begin
                if (h_q == h_end_q) begin
                    h_d = h_start_q;
                    v_d = v_q + COOR_WIDTH'(1);
                end else begin
                    h_d = h_q + COOR_WIDTH'(1);
                end
                if (hit_now) hit_d = 1'b1;
`ifdef COLLISION_EARLY_EXIT_EN
                if (last_w || hit_now) begin
`else
                if (last_w) begin
`endif
                    state_d = S_DONE;
                    col_d   = hit_q | hit_now;
                end
            end
            S_DONE: begin
                if (!i_start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            h_q       <= '0;
            v_q       <= '0;
            h_start_q <= '0;
            h_end_q   <= '0;
            v_end_q   <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            hit_q     <= 1'b0;
            col_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            h_start_q <= h_start_d;
            h_end_q   <= h_end_d;
            v_end_q   <= v_end_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            hit_q     <= hit_d;
            col_q     <= col_d;
        end
    end

    assign o_busy      = (state_q == S_SETUP) || (state_q == S_SCAN);
    assign o_done      = (state_q == S_DONE);
    assign o_collision = col_q;

endmodule

// File: tb/tb_sprite_collision_detector.sv
// Randomized bench for sprite_collision_detector against a whole-sprite overlap reference model.
module tb_sprite_collision_detector;

    localparam int IS = 32;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_opacity_valid, i_opacity, i_start;
    logic [1:0]  i_object_id;
    logic [9:0]  i_pixel_index;
    logic [10:0] i_car1_x, i_car1_y, i_car2_x, i_car2_y;
    logic        o_busy, o_done, o_collision;

    int n_cmp = 0;
    int n_err = 0;
    bit m1[IS*IS];
    bit m2[IS*IS];

    sprite_collision_detector #(
        .IMAGE_SIZE(32), .COOR_WIDTH(5), .POS_WIDTH(11), .CAR1_ID(0), .CAR2_ID(1)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opacity_valid(i_opacity_valid),
        .i_opacity(i_opacity), .i_object_id(i_object_id), .i_pixel_index(i_pixel_index),
        .i_start(i_start), .i_car1_x(i_car1_x), .i_car1_y(i_car1_y),
        .i_car2_x(i_car2_x), .i_car2_y(i_car2_y), .o_busy(o_busy), .o_done(o_done),
        .o_collision(o_collision)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int id, input int idx, input bit val);
        i_opacity_valid = 1'b1;
        i_object_id     = 2'(id);
        i_pixel_index   = 10'(idx);
        i_opacity       = val;
        @(posedge i_clk); #1;
        i_opacity_valid = 1'b0;
    endtask

    task automatic stream_all();
        for (int i = 0; i < IS*IS; i++) send(0, i, m1[i]);
        for (int i = 0; i < IS*IS; i++) send(1, i, m2[i]);
    endtask

    task automatic set_px(input int id, input int h, input int v, input bit val);
        if (id == 0) m1[v*IS+h] = val;
        if (id == 1) m2[v*IS+h] = val;
        send(id, v*IS+h, val);
    endtask

    // Visit every car1 pixel, map into car2 space, keep raster order of in-range pixels.
    function automatic void model(input int dx, input int dy, output int col, output int lat);
        int k = 0;
        int first = -1;
        if (dx >= IS || -dx >= IS || dy >= IS || -dy >= IS) begin
            col = 0;
            lat = 1;
            return;
        end
        for (int v1 = 0; v1 < IS; v1++)
            for (int h1 = 0; h1 < IS; h1++) begin
                int h2 = h1 - dx;
                int v2 = v1 - dy;
                if (h2 >= 0 && h2 < IS && v2 >= 0 && v2 < IS) begin
                    if (first < 0 && m1[v1*IS+h1] && m2[v2*IS+h2]) first = k;
                    k++;
                end
            end
        col = (first >= 0) ? 1 : 0;
`ifdef COLLISION_EARLY_EXIT_EN
        lat = (first >= 0) ? first + 2 : k + 1;
`else
        lat = k + 1;
`endif
    endfunction

    task automatic run_check(input string tag, input int x1, input int y1,
                             input int x2, input int y2, input bit inject);
        int ecol, elat, edge_n, busy_cnt;
        model(x2 - x1, y2 - y1, ecol, elat);
        i_car1_x = 11'(x1);
        i_car1_y = 11'(y1);
        i_car2_x = 11'(x2);
        i_car2_y = 11'(y2);
        i_start  = 1'b1;
        edge_n   = -1;
        busy_cnt = 0;
        while (edge_n < 1200) begin
            @(posedge i_clk); #1;
            edge_n++;
            if (inject && edge_n == 4) begin
                i_opacity_valid = 1'b1;
                i_object_id     = 2'd0;
                i_pixel_index   = 10'd20;
                i_opacity       = 1'b1;
            end else begin
                i_opacity_valid = 1'b0;
            end
            if (edge_n == 1 && !o_done) check_eq({tag, ".clr"}, int'(o_collision), 0);
            if (o_busy) busy_cnt++;
            if (o_done) break;
        end
        check_eq({tag, ".lat"}, edge_n, elat);
        check_eq({tag, ".col"}, int'(o_collision), ecol);
        check_eq({tag, ".busy"}, busy_cnt, elat);
        repeat (2) begin @(posedge i_clk); #1; end
        check_eq({tag, ".hold"}, int'(o_done), 1);
        i_start = 1'b0;
        @(posedge i_clk); #1;
        check_eq({tag, ".idle"}, int'(o_done), 0);
        check_eq({tag, ".keep"}, int'(o_collision), ecol);
    endtask

    initial begin
        int den, x1, y1;
        i_rst_n = 1'b0; i_opacity_valid = 1'b0; i_opacity = 1'b0; i_start = 1'b0;
        i_object_id = '0; i_pixel_index = '0;
        i_car1_x = '0; i_car1_y = '0; i_car2_x = '0; i_car2_y = '0;
        foreach (m1[i]) begin m1[i] = 1'b0; m2[i] = 1'b0; end
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("rst.busy", int'(o_busy), 0);
        check_eq("rst.done", int'(o_done), 0);
        check_eq("rst.col", int'(o_collision), 0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        foreach (m1[i]) begin m1[i] = 1'b1; m2[i] = 1'b1; end
        stream_all();
        run_check("diag31", 100, 100, 131, 131, 1'b0);
        run_check("far_x", 100, 100, 132, 100, 1'b0);
        run_check("far_y", 100, 100, 100, 68, 1'b0);
        run_check("far_big", 2000, 5, 5, 5, 1'b0);
        run_check("same1", 100, 100, 100, 100, 1'b0);
        run_check("diagm31", 100, 100, 69, 69, 1'b0);

        foreach (m1[i]) begin m1[i] = (i % IS) < 16; m2[i] = (i % IS) >= 16; end
        stream_all();
        run_check("halves", 200, 50, 200, 50, 1'b1);
        run_check("halves2", 200, 50, 200, 50, 1'b0);

        foreach (m1[i]) begin m1[i] = 1'b0; m2[i] = 1'b0; end
        m1[0] = 1'b1;
        m2[5*IS+10] = 1'b1;
        stream_all();
        run_check("neg_hit", 100, 100, 90, 95, 1'b0);
        set_px(1, 10, 5, 1'b0);
        set_px(1, 11, 5, 1'b1);
        run_check("neg_miss", 100, 100, 90, 95, 1'b0);
        send(2, 5*IS+10, 1'b1);
        send(3, 0, 1'b0);
        run_check("id2", 100, 100, 90, 95, 1'b0);

        for (int r = 0; r < 4; r++) begin
            den = 2 + r * 6;
            foreach (m1[i]) begin
                m1[i] = ($urandom_range(den - 1, 0) == 0);
                m2[i] = ($urandom_range(den - 1, 0) == 0);
            end
            stream_all();
            for (int t = 0; t < 2; t++) begin
                x1 = 100 + int'($urandom_range(500, 0));
                y1 = 100 + int'($urandom_range(500, 0));
                run_check("rand", x1, y1, x1 + int'($urandom_range(70, 0)) - 35,
                          y1 + int'($urandom_range(70, 0)) - 35, 1'b0);
            end
        end

        foreach (m1[i]) begin m1[i] = 1'b1; m2[i] = 1'b1; end
        stream_all();
        i_car1_x = 11'd100; i_car1_y = 11'd100; i_car2_x = 11'd100; i_car2_y = 11'd100;
        i_start = 1'b1;
        repeat (501) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        #1;
        check_eq("midrst.busy", int'(o_busy), 0);
        check_eq("midrst.done", int'(o_done), 0);
        check_eq("midrst.col", int'(o_collision), 0);
        foreach (m1[i]) begin m1[i] = 1'b0; m2[i] = 1'b0; end
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        run_check("postrst", 100, 100, 100, 100, 1'b0);
        foreach (m1[i]) begin m1[i] = 1'b1; m2[i] = 1'b1; end
        stream_all();
        run_check("recap", 100, 100, 100, 100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
